// File: rtl/mlp_serial_scheduler_if.sv
// Handshake bundle for the serial MLP scheduler: the sample stream in, the class result out, and debug taps.
interface mlp_serial_scheduler_if #(
   parameter int IN_W  = 4,
   parameter int HID_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [6*IN_W-1:0]    inp;
   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           out_class;
   logic [3*HID_W-1:0]   dbg_hidden;
   logic                 busy;

   modport master (
      output in_valid, inp, out_ready,
      input  in_ready, out_valid, out_class, dbg_hidden, busy
   );

   modport slave (
      input  in_valid, inp, out_ready,
      output in_ready, out_valid, out_class, dbg_hidden, busy
   );
endinterface

// File: rtl/mlp_serial_scheduler.sv
// Serial evaluation of the 6-in / 3-hidden / 2-out power-of-two MLP.
// A single shift-add accumulator takes one weighted term per cycle across all five neurons.
module mlp_serial_scheduler #(
   parameter int IN_W  = 4,
   parameter int HID_W = 8,
   parameter int OUT_W = 16,
   parameter int ACC_W = 18
) (
   input logic                clk,
   input logic                rst_n,
   mlp_serial_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      L0_MAC,
      L0_ACT,
      L1_MAC,
      L1_ACT,
      ARGMAX,
      DONE
   } state_t;

   state_t                      state;
   logic [6*IN_W-1:0]           x_reg;
   logic [1:0]                  neuron;
   logic [2:0]                  term_idx;
   logic signed [ACC_W-1:0]     acc;
   logic [OUT_W-1:0]            o0;
   logic [OUT_W-1:0]            o1;
   logic [3*HID_W-1:0]          hidden;
   logic                        in_ready_r;
   logic                        out_valid_r;
   logic                        busy_r;
   logic [1:0]                  out_class_r;

   logic [HID_W-1:0]            operand;
   logic [4:0]                  code;
   logic signed [ACC_W-1:0]     bias;
   logic signed [ACC_W-1:0]     term;
   logic signed [ACC_W-1:0]     mac_sum;

   // Weight code: {zero, negative, shift[2:0]}; weight = +/- 2^shift, or 0 when zero is set.
   function automatic logic [4:0] l0_code(input logic [1:0] n, input logic [2:0] i);
      logic [4:0] c;
      case ({n, i})
         5'b00_000: c = 5'b00101;
         5'b00_001: c = 5'b01101;
         5'b00_010: c = 5'b00011;
         5'b00_011: c = 5'b00110;
         5'b00_100: c = 5'b01110;
         5'b00_101: c = 5'b00110;
         5'b01_000: c = 5'b01101;
         5'b01_001: c = 5'b00101;
         5'b01_010: c = 5'b01011;
         5'b01_011: c = 5'b01011;
         5'b01_100: c = 5'b01100;
         5'b01_101: c = 5'b00110;
         5'b10_000: c = 5'b00100;
         5'b10_001: c = 5'b00101;
         5'b10_010: c = 5'b00010;
         5'b10_011: c = 5'b01011;
         5'b10_100: c = 5'b01101;
         5'b10_101: c = 5'b00110;
         default:   c = 5'b10000;
      endcase
      return c;
   endfunction

   function automatic logic [4:0] l1_code(input logic [1:0] n, input logic [2:0] i);
      logic [4:0] c;
      case ({n[0], i[1:0]})
         3'b0_00: c = 5'b00100;
         3'b0_01: c = 5'b00110;
         3'b0_10: c = 5'b00011;
         3'b1_00: c = 5'b01100;
         3'b1_01: c = 5'b01110;
         default: c = 5'b10000;
      endcase
      return c;
   endfunction

   function automatic logic signed [ACC_W-1:0] l0_bias(input logic [1:0] n);
      logic signed [ACC_W-1:0] b;
      case (n)
         2'd0:    b = ACC_W'(128);
         2'd1:    b = ACC_W'(128);
         default: b = ACC_W'(-256);
      endcase
      return b;
   endfunction

   function automatic logic signed [ACC_W-1:0] l1_bias(input logic [1:0] n);
      return n[0] ? ACC_W'(1024) : ACC_W'(-1024);
   endfunction

   function automatic logic signed [ACC_W-1:0] shift_term(input logic [HID_W-1:0] v,
                                                          input logic [4:0]       c);
      logic signed [ACC_W-1:0] m;
      logic signed [ACC_W-1:0] r;
      m = signed'({{(ACC_W-HID_W){1'b0}}, v}) <<< c[2:0];
      if (c[4])      r = '0;
      else if (c[3]) r = -m;
      else           r = m;
      return r;
   endfunction

   // Hidden activation: clamp negatives to 0, truncate by 4, saturate at the top of HID_W.
   function automatic logic [HID_W-1:0] qrelu_hidden(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      logic [HID_W-1:0]        r;
      s = a >>> 2;
      if (a[ACC_W-1])             r = '0;
      else if (|s[ACC_W-1:HID_W]) r = '1;
      else                        r = s[HID_W-1:0];
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] relu_out(input logic signed [ACC_W-1:0] a);
      return a[ACC_W-1] ? '0 : a[OUT_W-1:0];
   endfunction

   always_comb begin
      operand = '0;
      code    = 5'b10000;
      bias    = '0;
      if (state == L1_MAC) begin
         operand = hidden[term_idx*HID_W +: HID_W];
         code    = l1_code(neuron, term_idx);
         bias    = l1_bias(neuron);
      end else begin
         operand = {{(HID_W-IN_W){1'b0}}, x_reg[term_idx*IN_W +: IN_W]};
         code    = l0_code(neuron, term_idx);
         bias    = l0_bias(neuron);
      end
      term    = shift_term(operand, code);
      mac_sum = ((term_idx == 3'd0) ? bias : acc) + term;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         x_reg       <= '0;
         neuron      <= '0;
         term_idx    <= '0;
         acc         <= '0;
         o0          <= '0;
         o1          <= '0;
         hidden      <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_class_r <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  x_reg      <= bus.inp;
                  neuron     <= '0;
                  term_idx   <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= L0_MAC;
               end
            end
            L0_MAC: begin
               acc <= mac_sum;
               if (term_idx == 3'd5) begin
                  term_idx <= '0;
                  state    <= L0_ACT;
               end else begin
                  term_idx <= term_idx + 3'd1;
               end
            end
            L0_ACT: begin
               hidden[neuron*HID_W +: HID_W] <= qrelu_hidden(acc);
               if (neuron == 2'd2) begin
                  neuron <= '0;
                  state  <= L1_MAC;
               end else begin
                  neuron <= neuron + 2'd1;
                  state  <= L0_MAC;
               end
            end
            L1_MAC: begin
               acc <= mac_sum;
               if (term_idx == 3'd2) begin
                  term_idx <= '0;
                  state    <= L1_ACT;
               end else begin
                  term_idx <= term_idx + 3'd1;
               end
            end
            L1_ACT: begin
               if (neuron == 2'd0) begin
                  o0     <= relu_out(acc);
                  neuron <= 2'd1;
                  state  <= L1_MAC;
               end else begin
                  o1     <= relu_out(acc);
                  neuron <= '0;
                  state  <= ARGMAX;
               end
            end
            ARGMAX: begin
               // Ties resolve to class 0.
               out_class_r <= (o0 >= o1) ? 2'd0 : 2'd1;
               out_valid_r <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_class  = out_class_r;
   assign bus.dbg_hidden = hidden;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mlp_serial_scheduler.sv
// Bench for the serial MLP scheduler: directed corner samples, backpressure, mid-run reset, random samples.
module tb_mlp_serial_scheduler;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mlp_serial_scheduler_if bus ();

   mlp_serial_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int W0 [3][6] = '{'{32, -32, 8, 64, -64, 64},
                     '{-32, 32, -8, -8, -16, 64},
                     '{16, 32, 4, -8, -32, 64}};
   int B0 [3]    = '{128, 128, -256};
   int W1 [2][3] = '{'{16, 64, 8}, '{-16, -64, 0}};
   int B1 [2]    = '{-1024, 1024};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Plain integer evaluation of the network straight from its weight tables.
   task automatic model(input logic [23:0] x, output logic [1:0] cls, output logic [23:0] hid);
      int h [3];
      int o [2];
      int s;
      for (int n = 0; n < 3; n++) begin
         s = B0[n];
         for (int i = 0; i < 6; i++) s += W0[n][i] * int'(x[4*i +: 4]);
         if (s < 0) h[n] = 0;
         else h[n] = (s / 4 > 255) ? 255 : s / 4;
      end
      for (int n = 0; n < 2; n++) begin
         s = B1[n];
         for (int i = 0; i < 3; i++) s += W1[n][i] * h[i];
         o[n] = (s < 0) ? 0 : s;
      end
      cls = (o[0] >= o[1]) ? 2'd0 : 2'd1;
      hid = {8'(h[2]), 8'(h[1]), 8'(h[0])};
   endtask

   task automatic run_sample(input logic [23:0] x, input int hold);
      logic [1:0]  cls;
      logic [23:0] hid;
      int          w;
      int          lat;
      model(x, cls, hid);
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_before", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.inp       = x;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.inp      = 24'($urandom);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      chk("busy_flag", 32'(bus.busy), 32'd1);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'd30);
      chk("out_class", 32'(bus.out_class), 32'(cls));
      chk("dbg_hidden", 32'(bus.dbg_hidden), 32'(hid));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_class", 32'(bus.out_class), 32'(cls));
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("after_valid", 32'(bus.out_valid), 32'd0);
      chk("after_in_ready", 32'(bus.in_ready), 32'd1);
      chk("after_hidden", 32'(bus.dbg_hidden), 32'(hid));
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      bus.in_valid  = 1'b0;
      bus.inp       = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_class", 32'(bus.out_class), 32'd0);
      chk("rst_hidden", 32'(bus.dbg_hidden), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_sample(24'h000000, 0);
      chk("t1_hidden", 32'(bus.dbg_hidden), 32'h000020_20);
      run_sample(24'hFFFFFF, 0);
      chk("t2_hidden", 32'(bus.dbg_hidden), 32'h00DD98FF);
      run_sample(24'h0F0000, 0);
      chk("t3_hidden", 32'(bus.dbg_hidden), 32'h00000000);
      run_sample(24'($urandom), 10);

      // Abort a sample partway through; nothing of it may survive.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.inp      = 24'hFFFFFF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_hidden", 32'(bus.dbg_hidden), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_sample(24'h0F0000, 0);

      for (int n = 0; n < 200; n++) begin
         run_sample(24'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
